// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 VGA timing decoder: recovers pixel position, checks line/frame lengths, reports lock.
// Optional error counter enabled with VGA_SYNC_DECODER_ERRCNT_EN (o_err_cnt tied to 0 otherwise).
//   state    | meaning
//   SEARCH   | waiting for a frame start, length checks ignored
//   TRACK    | counting consecutive good frames toward lock
//   LOCKED   | timing verified, position outputs valid
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pix_stb,
    input  logic       i_hs,
    input  logic       i_vs,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_active,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output logic [7:0] o_err_cnt
);
    localparam logic [9:0] H_TOTAL = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] V_TOTAL = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic [1:0] state_q, state_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;
    logic [3:0] good_q, good_d;
    logic       hs_q, hs_d;
    logic       vs_line_q, vs_line_d;
    logic       vs_seen_q, vs_seen_d;
    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic       active_q, active_d;
    logic       fs_q, fs_d;
    logic       locked_q, locked_d;
    logic       err_q;
    logic       hs_fall, frm_start, viol, err_ev, vis;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        good_d    = good_q;
        hs_d      = hs_q;
        vs_line_d = vs_line_q;
        vs_seen_d = vs_seen_q;
        hs_fall   = 1'b0;
        frm_start = 1'b0;
        viol      = 1'b0;
        err_ev    = 1'b0;
        if (i_pix_stb) begin
            hs_d    = i_hs;
            hs_fall = hs_q & ~i_hs;
            // a frame start only counts once a VS-high line has been seen since reset
            frm_start = hs_fall & vs_seen_q & vs_line_q & ~i_vs;
            if (hs_fall) begin
                hcnt_d    = '0;
                vs_line_d = i_vs;
                vs_seen_d = vs_seen_q | i_vs;
                if (hcnt_q != H_TOTAL - 10'd1) viol = 1'b1;
                if (frm_start) begin
                    vcnt_d = '0;
                    if (vcnt_q != V_TOTAL - 10'd1) viol = 1'b1;
                end else if (vcnt_q != V_TOTAL) begin
                    vcnt_d = vcnt_q + 10'd1;
                    if (vcnt_q == V_TOTAL - 10'd1) viol = 1'b1;
                end
            end else if (hcnt_q != H_TOTAL) begin
                hcnt_d = hcnt_q + 10'd1;
                if (hcnt_q == H_TOTAL - 10'd1) viol = 1'b1;
            end

            case (state_q)
                ST_SEARCH: begin
                    if (frm_start) begin
                        state_d = ST_TRACK;
                        good_d  = '0;
                    end
                end
                ST_TRACK, ST_LOCKED: begin
                    if (viol) begin
                        state_d = ST_SEARCH;
                        err_ev  = 1'b1;
                    end else if (frm_start && state_q == ST_TRACK) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        // with no strobe the next-state equals the current state, so outputs recompute to the held values
        locked_d = (state_d == ST_LOCKED);
        vis      = locked_d && (hcnt_d >= H_START) && (hcnt_d <= H_END) &&
                   (vcnt_d >= V_START) && (vcnt_d <= V_END);
        x_d      = vis ? (hcnt_d - H_START) : '0;
        y_d      = vis ? 9'(vcnt_d - V_START) : '0;
        active_d = vis;
        fs_d     = i_pix_stb & vis & (hcnt_d == H_START) & (vcnt_d == V_START);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_SEARCH;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            good_q    <= '0;
            hs_q      <= 1'b1;
            vs_line_q <= 1'b1;
            vs_seen_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            active_q  <= 1'b0;
            fs_q      <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            good_q    <= good_d;
            hs_q      <= hs_d;
            vs_line_q <= vs_line_d;
            vs_seen_q <= vs_seen_d;
            x_q       <= x_d;
            y_q       <= y_d;
            active_q  <= active_d;
            fs_q      <= fs_d;
            locked_q  <= locked_d;
            err_q     <= err_ev;
        end
    end

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_ev && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = '0;
`endif

    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_active      = active_q;
    assign o_frame_start = fs_q;
    assign o_locked      = locked_q;
    assign o_err         = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder with a reduced timing (25x13 totals) to keep frames short.
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
    localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
    localparam int LF = 2;
    localparam int HT = HA + HF + HSW + HB;   // 25
    localparam int VT = VA + VF + VSW + VB;   // 13
    localparam int HO = HSW + HB;             // 7
    localparam int VO = VSW + VB;             // 5
`ifdef VGA_SYNC_DECODER_ERRCNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       i_rst = 1'b1, i_pix_stb = 1'b0, i_hs = 1'b1, i_vs = 1'b1;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_active, o_frame_start, o_locked, o_err;
    logic [7:0] o_err_cnt;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb), .i_hs(i_hs), .i_vs(i_vs),
        .o_x(o_x), .o_y(o_y), .o_active(o_active), .o_frame_start(o_frame_start),
        .o_locked(o_locked), .o_err(o_err), .o_err_cnt(o_err_cnt)
    );

    int checks = 0, passed = 0, err_pulses = 0;
    bit chk_en = 0;

    // model: positions from strobe timestamps of the last HS fall and a line count since frame start
    int n, last_fall, m_lines, m_mode, m_good, m_cnt;
    bit m_prev_hs, m_line_vs;
    int exp_x, exp_y, exp_act, exp_fs, exp_lk, exp_err, exp_cnt;

    task automatic model_reset();
        n = 0; last_fall = 0; m_lines = 0; m_mode = 0; m_good = 0; m_cnt = 0;
        m_prev_hs = 1; m_line_vs = 0;
        exp_x = 0; exp_y = 0; exp_act = 0; exp_fs = 0; exp_lk = 0; exp_err = 0; exp_cnt = 0;
    endtask

    task automatic model_step(input bit stb, input bit hs, input bit vs);
        int age, hpos;
        bit fall, fs, viol, vis;
        exp_fs = 0; exp_err = 0;
        if (!stb) return;
        n++;
        age = n - last_fall;
        fall = m_prev_hs && !hs;
        m_prev_hs = hs;
        fs = 0; viol = 0;
        if (fall) begin
            fs = m_line_vs && !vs;
            m_line_vs = vs;
            if (age != HT) viol = 1;
            if (fs) begin
                if (m_lines != VT - 1) viol = 1;
                m_lines = 0;
            end else begin
                if (m_lines == VT - 1) viol = 1;
                if (m_lines < VT) m_lines++;
            end
            last_fall = n;
            hpos = 0;
        end else begin
            if (age == HT) viol = 1;
            hpos = (age > HT) ? HT : age;
        end
        if (m_mode == 0) begin
            if (fs) begin m_mode = 1; m_good = 0; end
        end else if (viol) begin
            m_mode = 0;
            exp_err = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (fs && m_mode == 1) begin
            m_good++;
            if (m_good >= LF) m_mode = 2;
        end
        exp_lk  = (m_mode == 2);
        vis     = exp_lk && hpos >= HO && hpos < HO + HA && m_lines >= VO && m_lines < VO + VA;
        exp_act = vis;
        exp_x   = vis ? hpos - HO : 0;
        exp_y   = vis ? m_lines - VO : 0;
        exp_fs  = vis && hpos == HO && m_lines == VO;
        exp_cnt = CNT_ON ? m_cnt : 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (o_err) err_pulses++;
        if (chk_en) begin
            checks++;
            if (int'(o_x) == exp_x && int'(o_y) == exp_y && int'(o_active) == exp_act &&
                int'(o_frame_start) == exp_fs && int'(o_locked) == exp_lk &&
                int'(o_err) == exp_err && int'(o_err_cnt) == exp_cnt)
                passed++;
            else
                $display("FAIL cycle t=%0t got x=%0d y=%0d act=%0d fs=%0d lk=%0d err=%0d cnt=%0d required x=%0d y=%0d act=%0d fs=%0d lk=%0d err=%0d cnt=%0d",
                         $time, o_x, o_y, o_active, o_frame_start, o_locked, o_err, o_err_cnt,
                         exp_x, exp_y, exp_act, exp_fs, exp_lk, exp_err, exp_cnt);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endtask

    task automatic step(input bit stb, input bit hs, input bit vs, input bit rst);
        @(negedge clk);
        i_rst = rst; i_pix_stb = stb; i_hs = hs; i_vs = vs;
        if (rst) model_reset();
        else model_step(stb, hs, vs);
        @(posedge clk);
        #2;
    endtask

    int pv = -1, ph = -1;
    int s_x, s_y, s_act, s_fs, s_lk, s_err, s_cnt;

    // generator with VS edges aligned to the HS leading edge
    task automatic pix(input int h, input int v);
        bit hs, vs;
        int vline;
        hs = !(h >= HA + HF && h < HA + HF + HSW);
        vline = (h >= HA + HF) ? v + 1 : v;
        vs = !(vline >= VA + VF && vline < VA + VF + VSW);
        step(1, hs, vs, 0);
        if (h == ph && v == pv) begin
            s_x = o_x; s_y = o_y; s_act = o_active; s_fs = o_frame_start;
            s_lk = o_locked; s_err = o_err; s_cnt = o_err_cnt;
        end
        step(0, hs, vs, 0);
    endtask

    task automatic gen_frame(input int nlines, input int stretch_v, input int p_v, input int p_h);
        pv = p_v; ph = p_h;
        for (int v = 0; v < nlines; v++)
            for (int h = 0; h < HT + ((v == stretch_v) ? 1 : 0); h++)
                pix(h, v);
        pv = -1; ph = -1;
    endtask

    task automatic line_raw(input int len, input bit vs);
        for (int i = 0; i < len; i++) begin
            step(1, i != 0, vs, 0);
            step(0, 1'b1, vs, 0);
        end
    endtask

    initial begin
        int hold_pulses;
        step(0, 1, 1, 1);
        chk_en = 1;
        step(0, 1, 1, 1);
        chk("reset_outputs", int'({o_x, o_y, o_active, o_frame_start, o_locked, o_err, o_err_cnt}), 0);

        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, 7, 18);
        chk("unlocked_after_fs2", s_lk, 0);
        gen_frame(VT, -1, 7, 18);
        chk("locked_after_fs3", s_lk, 1);
        gen_frame(VT, -1, 0, 0);
        chk("origin_x", s_x, 0);
        chk("origin_y", s_y, 0);
        chk("origin_active", s_act, 1);
        chk("origin_frame_start", s_fs, 1);
        gen_frame(VT, -1, VA - 1, HA - 1);
        chk("last_x", s_x, 15);
        chk("last_y", s_y, 5);
        gen_frame(VT, -1, 0, HA);
        chk("past_line_active", s_act, 0);
        chk("past_line_x", s_x, 0);
        chk("clean_no_err", err_pulses, 0);

        gen_frame(VT, 2, 3, 17);
        chk("stretch_err", s_err, 1);
        chk("stretch_unlock", s_lk, 0);
        chk("stretch_cnt", s_cnt, CNT_ON);
        gen_frame(VT, -1, 7, 18);
        chk("stretch_relock_fs2", s_lk, 0);
        gen_frame(VT, -1, 7, 18);
        chk("stretch_relock_fs3", s_lk, 1);

        gen_frame(VT - 1, -1, -1, -1);
        gen_frame(VT, -1, 7, 18);
        chk("short_frame_err", s_err, 1);
        chk("short_frame_unlock", s_lk, 0);
        chk("short_frame_cnt", s_cnt, 2 * CNT_ON);
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, -1, -1);
        gen_frame(VT, -1, 7, 18);
        chk("short_relock", s_lk, 1);

        pv = 3; ph = 9;
        for (int v = 0; v < 3; v++)
            for (int h = 0; h < HT; h++) pix(h, v);
        for (int h = 0; h < 10; h++) pix(h, 3);
        pv = -1; ph = -1;
        chk("pre_idle_x", s_x, 9);
        hold_pulses = err_pulses;
        for (int i = 0; i < 100; i++) step(0, 1, 1, 0);
        chk("idle_x_frozen", int'(o_x), 9);
        chk("idle_y_frozen", int'(o_y), 3);
        chk("idle_no_err", err_pulses, hold_pulses);
        for (int h = 10; h < HT; h++) pix(h, 3);
        for (int h = 0; h < 5; h++) pix(h, 4);
        step(0, 1, 1, 1);
        chk("midframe_reset_outputs", int'({o_x, o_y, o_active, o_frame_start, o_locked, o_err, o_err_cnt}), 0);
        for (int h = 5; h < HT; h++) pix(h, 4);
        for (int v = 5; v < VT; v++)
            for (int h = 0; h < HT; h++) pix(h, v);
        gen_frame(VT, -1, 7, 18);
        chk("reset_relock_fs2", s_lk, 0);
        gen_frame(VT, -1, 7, 18);
        chk("reset_relock_fs3", s_lk, 1);

        step(0, 1, 1, 1);
        err_pulses = 0;
        for (int i = 0; i < 300; i++) begin
            line_raw(3, 1);
            line_raw(3, 0);
            line_raw(3, 0);
        end
        chk("inject_pulses", err_pulses, 300);
        chk("inject_cnt", int'(o_err_cnt), 255 * CNT_ON);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d passed=%0d", checks, passed);
        $fatal(1);
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator.
- Samples HS/VS on the pixel strobe and recovers the pixel position, active-video flag and frame-start pulse.
- Checks line and frame lengths against nominal timing and reports lock and errors.
- Used in-system to monitor the game's VGA output, and in benches as the scoreboard front end.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (strobes)
H_SYNC, 96, HS low width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS low width (lines)
V_BP, 33, vertical back porch
LOCK_FRAMES, 2, consecutive good frames needed for lock (1..15)

Ports:
i_clk  in  1  system clock (100 MHz)
i_rst  in  1  synchronous active-high reset
i_pix_stb  in  1  pixel strobe, one clk wide (25 MHz rate)
i_hs  in  1  horizontal sync, active low
i_vs  in  1  vertical sync, active low
o_x  out  10  active pixel column, 0 when not active
o_y  out  9  active pixel row, 0 when not active
o_active  out  1  current pixel is visible and decoder locked
o_frame_start  out  1  one-clk pulse at pixel (0,0) while locked
o_locked  out  1  timing verified
o_err  out  1  one-clk pulse on any timing violation
o_err_cnt  out  8  saturating error count (see Optional Feature)

Behaviour:
- Derived constants: H_TOTAL = 800 and V_TOTAL = 525 at defaults.
- All state advances only on clocks with i_pix_stb=1; otherwise everything holds, except o_frame_start and o_err, which are forced to 0.
- Outputs are registered: one clk latency from the strobe that presents HS/VS.
- Sync sampling:
  - hs_q and vs_q are registered on each strobe.
  - HS fall = hs_q=1 and i_hs=0.
- hcnt (10b):
  - HS fall sets it to 0; otherwise it increments.
  - It saturates at H_TOTAL; reaching H_TOTAL is an error.
- Line boundary = HS fall. At each line boundary, i_vs is sampled into vs_line.
  - Frame start = vs_line_prev=1 and i_vs=0. It sets vcnt=0.
  - Otherwise vcnt increments, saturating at V_TOTAL; reaching V_TOTAL is an error.
  - HS fall and a VS edge on the same strobe: use the current i_vs.
- Visible region: hcnt in [H_SYNC+H_BP, +H_ACTIVE-1] (144..783) and vcnt in [V_SYNC+V_BP, +V_ACTIVE-1] (35..514).
  - o_x = hcnt-144, o_y = vcnt-35, o_active=1, gated by o_locked.
  - Outside the region or when unlocked: o_x=0, o_y=0, o_active=0.
- o_frame_start=1 for the clk after the strobe where hcnt=144 and vcnt=35, while locked.
- FSM:
  - SEARCH: ignore length checks. Frame start → TRACK, good=0.
  - TRACK: at each HS fall, the line length (hcnt+1) must equal H_TOTAL. At frame start, the previous vcnt must equal V_TOTAL-1; if so, good++. When good reaches LOCK_FRAMES → LOCKED.
  - LOCKED: same checks. o_locked=1.
  - Any violation in TRACK or LOCKED (bad line length, bad frame length, hcnt/vcnt saturation): o_err pulse, → SEARCH, o_locked=0 on the same clk as the pulse.
- Reset (any time, including mid-frame), values on the next clk:
  - state=SEARCH; hcnt, vcnt and good all 0.
  - hs_q=1, vs_q=1, vs_line_prev=1.
  - All outputs 0, o_err_cnt=0.
  - The first frame start after reset needs a VS-high line observed first.

Optional Feature:
VGA_SYNC_DECODER_ERRCNT_EN
- Defined: o_err_cnt increments on each o_err pulse, saturates at 255, and clears only on i_rst.
- Undefined: no counter logic; o_err_cnt tied to 0. o_err is still generated.

Test Plan:
- Reset, then clean 640x480 generator stream, 4 frames → o_locked rises on the clk after the 3rd frame-start HS fall and stays 1; o_err never pulses.
- Locked; generator at h=0,v=0 → next clk o_x=0, o_y=0, o_active=1, o_frame_start=1. At h=639,v=479 → o_x=639, o_y=479. At h=640 → o_active=0, o_x=0.
- Locked; one line stretched to 801 strobes → o_err pulse when hcnt hits 800, o_locked=0, o_err_cnt=1 (macro on). Relock after 3 further frame starts.
- Locked; one frame of 524 lines → o_err at that frame start, state SEARCH, o_locked=0.
- i_pix_stb held low for 100 clks mid-line → o_x/o_y/hcnt frozen, no error. Reset asserted mid-frame → all outputs 0 next clk, and no lock until 3 frame starts later.
- Macro on, 300 injected errors → o_err_cnt=255. Macro off, same stimulus → o_err_cnt=0, 300 o_err pulses.
